// File: rtl/debouncer.sv
// Two-flop synchronizer plus a qualification FSM. A level reaches out only after it has held
// for STABLE_CYCLES consecutive synchronized samples.
// Optional rise/fall edge pulses are built only when DEBOUNCER_EDGE_PULSE_EN is defined.
module debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        StStableLo,
        StChkHi,
        StStableHi,
        StChkLo
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             sync0_q, sync1_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_d, fall_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            state_q <= StStableLo;
            cnt_q   <= '0;
        end else begin
            sync0_q <= d_in;
            sync1_q <= sync0_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a single sample matching the current level aborts with no credit kept
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStableLo: begin
                if (sync1_q) begin
                    state_d = StChkHi;
                    cnt_d   = CntOne;
                end
            end
            StChkHi: begin
                if (!sync1_q) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_q >= CntMax) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStableHi: begin
                if (!sync1_q) begin
                    state_d = StChkLo;
                    cnt_d   = CntOne;
                end
            end
            StChkLo: begin
                if (sync1_q) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_q >= CntMax) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        out  = 1'b0;
        busy = 1'b0;
        unique case (state_q)
            StStableLo: begin
                out  = 1'b0;
                busy = 1'b0;
            end
            StChkHi: begin
                out  = 1'b0;
                busy = 1'b1;
            end
            StStableHi: begin
                out  = 1'b1;
                busy = 1'b0;
            end
            StChkLo: begin
                out  = 1'b1;
                busy = 1'b1;
            end
            default: begin
                out  = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    logic unused_pulse;
    assign unused_pulse = rise_d ^ fall_d;
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: stimulus pushes hand-computed per-cycle expectations into a
// queue and a separate monitor pops and compares them after every rising edge.
module tb_debouncer;

    logic clk;
    logic reset;
    logic d_in;
    logic out, rise, fall, busy;

    int n_tests;
    int n_fail;

    // {out, busy, rise, fall}
    logic [3:0] exp_q[$];

    debouncer #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .d_in (d_in),
        .out  (out),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got queue depth %0d, want 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: one expectation per rising edge, checked shortly after the edge
    initial begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        int         cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {out, busy, rise, fall};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL cycle%0d: got out/busy/rise/fall=%b want %b", cyc, act_v,
                             exp_v);
                end
                cyc++;
            end
        end
    end

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Called at a negedge: drive d_in, queue the outputs expected after the next rising edge.
    task automatic step(input logic d, input logic o, input logic b, input logic r,
                        input logic f);
        logic rr, ff;
`ifdef DEBOUNCER_EDGE_PULSE_EN
        rr = r;
        ff = f;
`else
        rr = 1'b0;
        ff = 1'b0;
`endif
        d_in = d;
        exp_q.push_back({o, b, rr, ff});
        @(negedge clk);
    endtask

    // Vectors read left to right: leftmost bit is cycle 0.
    task automatic seq(input int n, input logic [31:0] dv, input logic [31:0] ov,
                       input logic [31:0] bv, input logic [31:0] rv, input logic [31:0] fv);
        for (int i = 0; i < n; i++) begin
            step(dv[n-1-i], ov[n-1-i], bv[n-1-i], rv[n-1-i], fv[n-1-i]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        d_in    = 1'b1;
        #1;
        check1("reset_out", {7'd0, out}, 8'd0);
        check1("reset_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Release with d_in=1: out rises at the 5th edge after the first sampling edge
        seq(8, 32'b11111111, 32'b00000111, 32'b00111000, 32'b00000100, 32'b0);
        // Qualified fall
        seq(8, 32'b00000000, 32'b11111000, 32'b00111000, 32'b0, 32'b00000100);
        // Two-period glitch never reaches out
        seq(8, 32'b11000000, 32'b0, 32'b00110000, 32'b0, 32'b0);
        // Ten periods of bounce then settle high
        seq(17, 32'b10101010101111111, 32'b00000000000000011, 32'b00101010101011100,
            32'b00000000000000010, 32'b0);

        // Async reset from out=1 clears immediately
        reset = 1'b0;
        #1;
        check1("async_out", {7'd0, out}, 8'd0);
        check1("async_cnt0", dut.cnt_q, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Climb to cnt=2, then reset mid-qualification
        seq(4, 32'b1111, 32'b0000, 32'b0011, 32'b0, 32'b0);
        check1("midq_busy", {7'd0, busy}, 8'd1);
        check1("midq_cnt", dut.cnt_q, 8'd2);
        reset = 1'b0;
        #1;
        check1("midq_rst_busy", {7'd0, busy}, 8'd0);
        check1("midq_rst_out", {7'd0, out}, 8'd0);
        check1("midq_rst_cnt", dut.cnt_q, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        // Full qualification repeats from scratch
        seq(8, 32'b11111111, 32'b00000111, 32'b00111000, 32'b00000100, 32'b0);

        repeat (3) @(negedge clk);
        check1("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debouncer.md
# debouncer

Input-conditioning stage that sits directly upstream of the team's `d_ff` register stage. It takes a raw, asynchronous, possibly bouncing single-bit input and synchronizes it into the `clk` domain. It then qualifies each change over a configurable number of consecutive cycles before presenting a clean level on `out`, which drives the downstream flop's `d`. Optional single-cycle edge pulses report each qualified transition.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive synchronized samples a new level must hold before `out` follows it. Legal range 2 .. 2^CNT_W-1.
- `CNT_W`, default 8: width of the qualification counter.

- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `d_in`  input  1  raw asynchronous input; no timing relation to `clk` assumed.
- `out`  output  1  debounced, registered level.
- `rise`  output  1  one-cycle pulse when `out` goes 0→1.
- `fall`  output  1  one-cycle pulse when `out` goes 1→0.
- `busy`  output  1  high while a candidate transition is being qualified.

## Operation
- Synchronizer: two flops, `sync0 <= d_in` and `sync1 <= sync0`. Only `sync1` is used by the logic.
- FSM states:
  - `STABLE_LO`: `out`=0.
  - `CHK_HI`: qualifying a 0→1 change.
  - `STABLE_HI`: `out`=1.
  - `CHK_LO`: qualifying a 1→0 change.
- Counter `cnt` is `CNT_W` bits wide and is 0 in both STABLE states.
- Transitions, evaluated each rising edge:
  - `STABLE_LO`, `sync1`=1 → `CHK_HI`, `cnt`<=1.
  - `CHK_HI`, `sync1`=0 → `STABLE_LO`, `cnt`<=0, no pulse.
  - `CHK_HI`, `sync1`=1, `cnt` < `STABLE_CYCLES`-1 → stay, `cnt`<=`cnt`+1.
  - `CHK_HI`, `sync1`=1, `cnt` == `STABLE_CYCLES`-1 → `STABLE_HI`, `out`<=1, `rise`<=1, `cnt`<=0.
  - `STABLE_HI`, `CHK_LO` and the path back to `STABLE_LO` mirror the above with the polarities swapped; `fall` pulses on entry to `STABLE_LO` from `CHK_LO`.
- `busy` = state is `CHK_HI` or `CHK_LO`. It is a registered state decode with no combinational path from `d_in`.
- `rise`/`fall` are registered and high for exactly one cycle. They are never both high in the same cycle.
- Any single `sync1` sample that matches the current `out` during a CHK state aborts qualification. A later change restarts from `cnt`=1; there is no partial credit.
- `cnt` never exceeds `STABLE_CYCLES`-1 and never wraps.

## Timing
- Reset values while `reset`=0: `sync0`=0, `sync1`=0, `out`=0, `rise`=0, `fall`=0, `busy`=0, `cnt`=0, state `STABLE_LO`. These take effect immediately, without waiting for a clock edge.
- Reset asserted mid-qualification discards the candidate, and no pulse is generated. After release, qualification restarts from scratch.
- Latency, with `d_in` changing before edge k and staying stable:
  - edge k: `sync0` updates.
  - edge k+1: `sync1` updates.
  - edge k+2: CHK entered.
  - edge k+1+`STABLE_CYCLES`: `out` and the edge pulse update. With default 4 this is edge k+5.
- Minimum accepted pulse width on `d_in` is `STABLE_CYCLES` clock periods. Anything shorter never reaches `out`.
- `d_in` toggling every cycle keeps the FSM oscillating between STABLE and CHK; `out` stays constant.

## Configuration
- `DEBOUNCER_EDGE_PULSE_EN` defined: `rise`/`fall` registers are built and behave as above.
- Not defined: `rise` and `fall` are tied to constant 0 and no pulse registers are inferred. Ports remain present; `out`, `busy` and latency are unchanged.

## Test plan
- Release from reset with `d_in` held at 1, `STABLE_CYCLES`=4:
  - `out`=0 and `busy`=0 during reset.
  - `out`=1 at the 5th rising edge after the first edge that sampled `d_in`=1.
  - `rise` high for exactly one cycle, `fall`=0 throughout.
- Glitch with `out`=0: `d_in`=1 for 2 clock periods, then 0:
  - `busy` pulses high.
  - `out` stays 0 and `rise` never asserts.
- Qualified fall with `out`=1: `d_in`→0 and held:
  - `out`=0 at edge k+5.
  - `fall` high for one cycle, `busy` low afterwards.
- Bounce with `out`=0: `d_in` toggles each period for 10 periods, then settles at 1:
  - `out` unchanged during the bounce.
  - `out` rises exactly 4 edges after `sync1` settles, with a single `rise` pulse.
- Asynchronous reset mid-qualification: assert `reset`=0 while `busy`=1 and `cnt`=2:
  - `busy`, `out` and `cnt` clear before the next edge.
  - After release with `d_in`=1, the full 4-cycle qualification repeats.
- Build without `DEBOUNCER_EDGE_PULSE_EN` and rerun scenarios 1 and 3:
  - `out` timing is identical.
  - `rise` and `fall` stay 0.
